// File: rtl/phys_reg_map_table_multi.sv
// Superscalar register alias table: RENAME_WIDTH lookups/renames and KILL_WIDTH rollbacks per cycle.
// Optional feature macro: PHYS_REG_MAP_TABLE_CHECKPOINT_EN (checkpoint_save/checkpoint_restore + one shadow table).
module phys_reg_map_table_multi #(
  parameter int ARCH_REGS    = 32,
  parameter int PHYS_REGS    = 64,
  parameter int RENAME_WIDTH = 2,
  parameter int KILL_WIDTH   = 2,
  localparam int AW = $clog2(ARCH_REGS),
  localparam int PW = $clog2(PHYS_REGS)
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic [AW-1:0] source_arch_reg_tag_0 [RENAME_WIDTH],
  input  logic [AW-1:0] source_arch_reg_tag_1 [RENAME_WIDTH],
  output logic [PW-1:0] source_phys_reg_tag_0 [RENAME_WIDTH],
  output logic [PW-1:0] source_phys_reg_tag_1 [RENAME_WIDTH],
  input  logic          new_map_valid [RENAME_WIDTH],
  input  logic [AW-1:0] new_map_dest_arch_reg_tag [RENAME_WIDTH],
  input  logic [PW-1:0] new_map_dest_phys_reg_tag [RENAME_WIDTH],
  output logic [PW-1:0] new_map_old_dest_phys_reg_tag [RENAME_WIDTH],
  input  logic          kill_map_valid [KILL_WIDTH],
  input  logic [AW-1:0] kill_map_dest_arch_reg_tag [KILL_WIDTH],
  input  logic [PW-1:0] kill_map_old_dest_phys_reg_tag [KILL_WIDTH],
  input  logic [PW-1:0] kill_map_new_dest_phys_reg_tag [KILL_WIDTH],
`ifdef PHYS_REG_MAP_TABLE_CHECKPOINT_EN
  input  logic          checkpoint_save,
  input  logic          checkpoint_restore,
`endif
  output logic          kill_mismatch
);

  // No handshake: every rename/kill lane is qualified by its own valid and is always accepted.
  logic [PW-1:0]         table_q [ARCH_REGS];
  logic [PW-1:0]         table_d [ARCH_REGS];
  logic [KILL_WIDTH-1:0] kill_flags;
  logic                  any_kill;

  // Bundle bypass: later (younger) lanes j < i override earlier ones, so the last match wins.
  always_comb begin
    for (int i = 0; i < RENAME_WIDTH; i++) begin
      source_phys_reg_tag_0[i]         = table_q[source_arch_reg_tag_0[i]];
      source_phys_reg_tag_1[i]         = table_q[source_arch_reg_tag_1[i]];
      new_map_old_dest_phys_reg_tag[i] = table_q[new_map_dest_arch_reg_tag[i]];
      for (int j = 0; j < i; j++) begin
        if (new_map_valid[j] && (new_map_dest_arch_reg_tag[j] != '0)) begin
          if (new_map_dest_arch_reg_tag[j] == source_arch_reg_tag_0[i])
            source_phys_reg_tag_0[i] = new_map_dest_phys_reg_tag[j];
          if (new_map_dest_arch_reg_tag[j] == source_arch_reg_tag_1[i])
            source_phys_reg_tag_1[i] = new_map_dest_phys_reg_tag[j];
          if (new_map_dest_arch_reg_tag[j] == new_map_dest_arch_reg_tag[i])
            new_map_old_dest_phys_reg_tag[i] = new_map_dest_phys_reg_tag[j];
        end
      end
    end
  end

  always_comb begin
    any_kill = 1'b0;
    for (int k = 0; k < KILL_WIDTH; k++) begin
      if (kill_map_valid[k]) any_kill = 1'b1;
    end
  end

  // Kills walk youngest to oldest so the oldest restore lands last; each lane checks the partially rolled-back entry.
  always_comb begin
    table_d    = table_q;
    kill_flags = '0;
    if (any_kill) begin
      for (int k = 0; k < KILL_WIDTH; k++) begin
        if (kill_map_valid[k] && (kill_map_dest_arch_reg_tag[k] != '0)) begin
          if (table_d[kill_map_dest_arch_reg_tag[k]] != kill_map_new_dest_phys_reg_tag[k])
            kill_flags[k] = 1'b1;
          table_d[kill_map_dest_arch_reg_tag[k]] = kill_map_old_dest_phys_reg_tag[k];
        end
      end
    end else begin
      for (int i = 0; i < RENAME_WIDTH; i++) begin
        if (new_map_valid[i] && (new_map_dest_arch_reg_tag[i] != '0))
          table_d[new_map_dest_arch_reg_tag[i]] = new_map_dest_phys_reg_tag[i];
      end
    end
  end

`ifdef PHYS_REG_MAP_TABLE_CHECKPOINT_EN
  logic [PW-1:0] shadow_q [ARCH_REGS];

  // Restore has priority over save, leaving the shadow untouched in that cycle.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int r = 0; r < ARCH_REGS; r++) shadow_q[r] <= PW'(r % PHYS_REGS);
    end else if (checkpoint_save && !checkpoint_restore) begin
      shadow_q <= table_d;
    end
  end
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int r = 0; r < ARCH_REGS; r++) table_q[r] <= PW'(r % PHYS_REGS);
      kill_mismatch <= 1'b0;
    end else begin
`ifdef PHYS_REG_MAP_TABLE_CHECKPOINT_EN
      if (checkpoint_restore) table_q <= shadow_q;
      else                    table_q <= table_d;
`else
      table_q <= table_d;
`endif
      kill_mismatch <= |kill_flags;
    end
  end

endmodule

// File: doc/phys_reg_map_table_multi.md
# phys_reg_map_table_multi

Superscalar register alias table for the OoO core: maps architectural to physical register tags for up to RENAME_WIDTH instructions per cycle. Supports in-bundle dependency bypass, returns displaced mappings for free-list/ROB use, and rolls back up to KILL_WIDTH mappings per cycle on squash. Sits in core between decode/dispatch and the ROB/free list; parametrised successor of phys_reg_map_table.

## Interface
- ARCH_REGS, 32: architectural registers; AW = $clog2(ARCH_REGS)
- PHYS_REGS, 64: physical registers; PW = $clog2(PHYS_REGS)
- RENAME_WIDTH, 2: rename lanes per cycle
- KILL_WIDTH, 2: rollback lanes per cycle
- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous active-low reset
- source_arch_reg_tag_0[RENAME_WIDTH]  in  AW  lane i rs
- source_arch_reg_tag_1[RENAME_WIDTH]  in  AW  lane i rt
- source_phys_reg_tag_0[RENAME_WIDTH]  out  PW  mapped rs, bypassed
- source_phys_reg_tag_1[RENAME_WIDTH]  out  PW  mapped rt, bypassed
- new_map_valid[RENAME_WIDTH]  in  1  lane i renames a destination
- new_map_dest_arch_reg_tag[RENAME_WIDTH]  in  AW
- new_map_dest_phys_reg_tag[RENAME_WIDTH]  in  PW
- new_map_old_dest_phys_reg_tag[RENAME_WIDTH]  out  PW  mapping displaced by lane i, bypassed
- kill_map_valid[KILL_WIDTH]  in  1  rollback lane k; lane 0 youngest
- kill_map_dest_arch_reg_tag[KILL_WIDTH]  in  AW
- kill_map_old_dest_phys_reg_tag[KILL_WIDTH]  in  PW  mapping to restore
- kill_map_new_dest_phys_reg_tag[KILL_WIDTH]  in  PW  mapping being removed
- kill_mismatch  out  1  registered: a kill's new tag did not match table

## Operation
- Table: ARCH_REGS entries × PW bits, flops. Reset: entry r = r (mod PHYS_REGS); kill_mismatch = 0.
- Arch reg 0: entry fixed 0; writes/kills to it ignored; lookups return 0.
- Lookup (comb): lane i source tag = table value, overridden by youngest lane j < i with new_map_valid[j] and matching arch tag (nonzero). Lane 0 reads table only. Same rule for new_map_old_dest_phys_reg_tag[i].
- Write: each valid new map updates its entry at next edge; same arch reg in several lanes → highest-index lane wins.
- Kill: applied lane 0 → KILL_WIDTH-1 in order; same arch reg in several lanes → highest-index (oldest) restore wins.
- Priority: any kill_map_valid in a cycle → all new_map writes that cycle ignored (frontend is flushed); lookups still computed.
- Mismatch check: kill lane k flags when kill_map_new_dest_phys_reg_tag[k] ≠ entry value after applying kills of lanes < k; kill_mismatch registered = OR of flags, cleared next cycle with no mismatch. Table still updated.

## Timing
- Lookups and old-tag outputs: zero-cycle combinational from current table + bundle.
- Writes/kills visible to lookups the cycle after the edge; no write-to-read bypass from registered state beyond the bundle rule.
- kill_mismatch: 1-cycle latency after offending kill.
- nRST low mid-operation: table and kill_mismatch return to reset values immediately; in-flight inputs dropped.

## Configuration
- PHYS_REG_MAP_TABLE_CHECKPOINT_EN defined: adds ports checkpoint_save (in, 1) and checkpoint_restore (in, 1) and one shadow table. Save copies the table as it will be after this cycle's writes/kills (post-update next state). Restore loads shadow into table at next edge, overriding all writes and kills that cycle; save+restore same cycle → restore wins, shadow unchanged. Shadow reset = identity.
- Undefined: no ports, no shadow; rollback only via kill lanes.

## Test plan
- Reset: after nRST deassert, lookup arch 5 → phys 5; arch 0 → 0; kill_mismatch = 0.
- Bundle bypass: lane0 maps r3→40, lane1 reads rs=r3 → 40 same cycle; lane1 old tag for r3 → 40; next cycle lane0 lookup r3 → 40.
- Same-reg collision: lane0 r7→41, lane1 r7→42 → next cycle r7 = 42; lane1 old tag = 41.
- Kill: after r3→40, r3→45, kill lane0 (r3 new 45 old 40) + lane1 (r3 new 40 old 3) → r3 = 3, kill_mismatch = 0; concurrent new_map r4→50 ignored (r4 = 4).
- Mismatch: kill r6 new 55 while table r6 = 6 → r6 = old tag given, kill_mismatch = 1 one cycle later, 0 the cycle after.
- Checkpoint (macro on): save with r2→33 same cycle, then r2→34, restore → r2 = 33; async nRST mid-sequence → r2 = 2.
